// File: rtl/riscv_pkg.sv
// Shared RV32I definitions: opcode constants, encoder FSM state codes, canonical NOP.
package riscv_pkg;

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_IMM   = 7'b0010011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_BRANCH= 7'b1100011;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;
  localparam logic [6:0] OP_JAL   = 7'b1101111;

  localparam logic [31:0] NOP = 32'h0000_0013;

  localparam int unsigned STATE_W = 2;
  typedef logic [STATE_W-1:0] state_t;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ACCEPT = 2'd1;
  localparam logic [1:0] ST_WRITE  = 2'd2;
  localparam logic [1:0] ST_DONE   = 2'd3;

endpackage

// File: rtl/riscv_inst_encoder_if.sv
// Field-bundle input handshake plus memory write port of the instruction encoder.
//   in_*  : producer -> encoder (valid/ready, decoded fields, last marker)
//   mem_* : encoder -> memory (we/addr/wdata), memory -> encoder (ack)
interface riscv_inst_encoder_if #(
  parameter int unsigned ADDR_W = 32
) ();
  logic              in_valid;
  logic              in_ready;
  logic [6:0]        in_opcode;
  logic [4:0]        in_rd;
  logic [4:0]        in_rs1;
  logic [4:0]        in_rs2;
  logic [2:0]        in_funct3;
  logic [6:0]        in_funct7;
  logic [31:0]       in_imm;
  logic              in_last;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic              mem_ack;

  // Producer / memory side.
  modport master (
    output in_valid, in_opcode, in_rd, in_rs1, in_rs2, in_funct3, in_funct7,
           in_imm, in_last, mem_ack,
    input  in_ready, mem_we, mem_addr, mem_wdata
  );

  // Encoder side.
  modport slave (
    input  in_valid, in_opcode, in_rd, in_rs1, in_rs2, in_funct3, in_funct7,
           in_imm, in_last, mem_ack,
    output in_ready, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/riscv_inst_pack.sv
// Combinational RV32I field packer with per-format immediate range/alignment checks.
//   inputs : opcode, rd, rs1, rs2, funct3, funct7, imm
//   outputs: word (NOP for unknown opcode), range_err_c, opcode_err_c
module riscv_inst_pack
  import riscv_pkg::*;
(
  input  logic [6:0]  opcode,
  input  logic [4:0]  rd,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic [2:0]  funct3,
  input  logic [6:0]  funct7,
  input  logic [31:0] imm,
  output logic [31:0] word_c,
  output logic        range_err_c,
  output logic        opcode_err_c
);

  // Upper bits must all be copies of the sign bit of the encodable field.
  logic sext12_ok, sext13_ok, sext21_ok;
  assign sext12_ok = (&imm[31:11]) | ~(|imm[31:11]);
  assign sext13_ok = (&imm[31:12]) | ~(|imm[31:12]);
  assign sext21_ok = (&imm[31:20]) | ~(|imm[31:20]);

  always_comb begin
    word_c       = NOP;
    range_err_c  = 1'b0;
    opcode_err_c = 1'b0;
    case (opcode)
      OP_R: begin
        word_c = {funct7, rs2, rs1, funct3, rd, opcode};
      end
      OP_IMM, OP_LOAD, OP_JALR: begin
        word_c      = {imm[11:0], rs1, funct3, rd, opcode};
        range_err_c = ~sext12_ok;
      end
      OP_STORE: begin
        word_c      = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
        range_err_c = ~sext12_ok;
      end
      OP_BRANCH: begin
        word_c      = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode};
        range_err_c = ~sext13_ok | imm[0];
      end
      OP_LUI, OP_AUIPC: begin
        word_c      = {imm[31:12], rd, opcode};
        range_err_c = |imm[11:0];
      end
      OP_JAL: begin
        word_c      = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode};
        range_err_c = ~sext21_ok | imm[0];
      end
      default: begin
        word_c       = NOP;
        opcode_err_c = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/riscv_inst_encoder.sv
// Session-based instruction encoder: accepts field bundles, packs them into RV32I
// words and writes them sequentially to memory with an ack handshake.
//   clk, rst (sync, active-high)
//   start/base_addr : open a session at base_addr (IDLE only)
//   bus             : field bundle in (valid/ready/last), memory write port out
//   busy/done       : session status, done is a one-cycle pulse
//   err_range/err_opcode : sticky per-session error flags
//   inst_count      : words written this session
module riscv_inst_encoder
  import riscv_pkg::*;
#(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  riscv_inst_encoder_if.slave bus,
  output logic              busy,
  output logic              done,
  output logic              err_range,
  output logic              err_opcode,
  output logic [CNT_W-1:0]  inst_count
);

  state_t            state_q, state_n;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q;
  logic              last_q;
  logic [31:0]       word_c;
  logic              range_err_c, opcode_err_c;
  logic              accept_c;

  riscv_inst_pack u_pack (
    .opcode       (bus.in_opcode),
    .rd           (bus.in_rd),
    .rs1          (bus.in_rs1),
    .rs2          (bus.in_rs2),
    .funct3       (bus.in_funct3),
    .funct7       (bus.in_funct7),
    .imm          (bus.in_imm),
    .word_c       (word_c),
    .range_err_c  (range_err_c),
    .opcode_err_c (opcode_err_c)
  );

  assign accept_c      = (state_q == ST_ACCEPT) && bus.in_valid;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_n;
  end

  // Next-state logic.
  always_comb begin
    state_n = state_q;
    case (state_q)
      ST_IDLE:   if (start)       state_n = ST_ACCEPT;
      ST_ACCEPT: if (bus.in_valid) state_n = ST_WRITE;
      ST_WRITE:  if (bus.mem_ack) state_n = last_q ? ST_DONE : ST_ACCEPT;
      ST_DONE:                    state_n = ST_IDLE;
      default:                    state_n = ST_IDLE;
    endcase
  end

  // Handshake/status outputs registered from the next state so they track state_q exactly.
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.in_ready <= 1'b0;
      bus.mem_we   <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
    end else begin
      bus.in_ready <= (state_n == ST_ACCEPT);
      bus.mem_we   <= (state_n == ST_WRITE);
      busy         <= (state_n != ST_IDLE);
      done         <= (state_n == ST_DONE);
    end
  end

  // Session datapath: address, encoded word, counters and sticky flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q     <= '0;
      wdata_q    <= '0;
      last_q     <= 1'b0;
      inst_count <= '0;
      err_range  <= 1'b0;
      err_opcode <= 1'b0;
    end else begin
      if ((state_q == ST_IDLE) && start) begin
        addr_q     <= base_addr;
        inst_count <= '0;
        err_range  <= 1'b0;
        err_opcode <= 1'b0;
      end
      if (accept_c) begin
        wdata_q    <= word_c;
        last_q     <= bus.in_last;
        err_range  <= err_range | range_err_c;
        err_opcode <= err_opcode | opcode_err_c;
      end
      if ((state_q == ST_WRITE) && bus.mem_ack) begin
        addr_q     <= addr_q + ADDR_W'(4);
        inst_count <= inst_count + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_riscv_inst_encoder.sv
// Self-checking bench for riscv_inst_encoder: vector table + scoreboard queue,
// plus hand sequences for ack stalls, ignored start/ack, and reset during WRITE.
module tb_riscv_inst_encoder;
  import riscv_pkg::*;

  logic        clk;
  logic        rst;
  logic        start;
  logic [31:0] base_addr;
  logic        busy, done, err_range, err_opcode;
  logic [15:0] inst_count;

  riscv_inst_encoder_if #(.ADDR_W(32)) bus ();

  riscv_inst_encoder #(.ADDR_W(32), .CNT_W(16)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .base_addr  (base_addr),
    .bus        (bus),
    .busy       (busy),
    .done       (done),
    .err_range  (err_range),
    .err_opcode (err_opcode),
    .inst_count (inst_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        first;
    logic [31:0] base;
    logic [6:0]  op;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [31:0] imm;
    logic        last;
    logic [31:0] word;
    logic        rerr;
    logic        oerr;
  } vec_t;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] word;
  } exp_t;

  localparam int unsigned NVEC = 19;
  vec_t vecs [NVEC];
  exp_t sb [$];

  int          total = 0;
  int          bad = 0;
  int          done_cnt = 0;
  int          cnt_m;
  logic [31:0] addr_m;
  logic        racc, oacc;

  always @(negedge clk) if (done === 1'b1) done_cnt++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic do_start(input logic [31:0] b);
    start = 1'b1;
    base_addr = b;
    @(negedge clk);
    start = 1'b0;
    addr_m = b;
    cnt_m = 0;
    racc = 1'b0;
    oacc = 1'b0;
    chk("start_busy", 32'(busy), 32'd1);
    chk("start_ready", 32'(bus.in_ready), 32'd1);
    chk("start_rerr", 32'(err_range), 32'd0);
    chk("start_oerr", 32'(err_opcode), 32'd0);
    chk("start_count", 32'(inst_count), 32'd0);
  endtask

  task automatic drive(input vec_t v);
    bus.in_opcode = v.op;
    bus.in_rd     = v.rd;
    bus.in_rs1    = v.rs1;
    bus.in_rs2    = v.rs2;
    bus.in_funct3 = v.f3;
    bus.in_funct7 = v.f7;
    bus.in_imm    = v.imm;
    bus.in_last   = v.last;
    bus.in_valid  = 1'b1;
    @(negedge clk);
    bus.in_valid  = 1'b0;
  endtask

  task automatic wait_we(output logic ok);
    int k;
    k = 0;
    while (bus.mem_we !== 1'b1 && k < 20) begin
      @(negedge clk);
      k++;
    end
    ok = (k < 20);
    if (!ok) chk("we_timeout", 32'd0, 32'd1);
  endtask

  task automatic send(input vec_t v, input int dly);
    int   k;
    logic ok;
    exp_t e;
    k = 0;
    while (bus.in_ready !== 1'b1 && k < 20) begin
      @(negedge clk);
      k++;
    end
    if (k >= 20) chk("ready_timeout", 32'd0, 32'd1);
    drive(v);
    sb.push_back('{addr: addr_m, word: v.word});
    addr_m = addr_m + 32'd4;
    racc = racc | v.rerr;
    oacc = oacc | v.oerr;
    wait_we(ok);
    e = '{addr: 32'hxxxx_xxxx, word: 32'hxxxx_xxxx};
    if (sb.size() > 0) e = sb.pop_front();
    chk("addr", bus.mem_addr, e.addr);
    chk("word", bus.mem_wdata, e.word);
    chk("err_range", 32'(err_range), 32'(racc));
    chk("err_opcode", 32'(err_opcode), 32'(oacc));
    chk("ready_in_write", 32'(bus.in_ready), 32'd0);
    for (int d = 0; d < dly; d++) begin
      @(negedge clk);
      chk("stall_we", 32'(bus.mem_we), 32'd1);
      chk("stall_addr", bus.mem_addr, e.addr);
      chk("stall_word", bus.mem_wdata, e.word);
      chk("stall_ready", 32'(bus.in_ready), 32'd0);
    end
    bus.mem_ack = 1'b1;
    @(negedge clk);
    bus.mem_ack = 1'b0;
    cnt_m++;
    chk("count", 32'(inst_count), 32'(cnt_m));
  endtask

  initial begin
    int   seen;
    logic ok;
    vec_t v;

    //               first base          op      rd     rs1    rs2    f3    f7      imm           last word          rerr  oerr
    vecs[0]  = '{1'b1, 32'h0000_0100, 7'h13, 5'd1,  5'd0, 5'd0, 3'd0, 7'h00, 32'h0000_0005, 1'b1, 32'h0050_0093, 1'b0, 1'b0};
    vecs[1]  = '{1'b1, 32'h0000_0200, 7'h63, 5'd0,  5'd1, 5'd2, 3'd0, 7'h00, 32'hFFFF_FFF8, 1'b0, 32'hFE20_8CE3, 1'b0, 1'b0};
    vecs[2]  = '{1'b0, 32'h0,         7'h6F, 5'd1,  5'd0, 5'd0, 3'd0, 7'h00, 32'h0000_0800, 1'b1, 32'h0010_00EF, 1'b0, 1'b0};
    vecs[3]  = '{1'b1, 32'h0000_0300, 7'h37, 5'd5,  5'd0, 5'd0, 3'd0, 7'h00, 32'h1234_5000, 1'b0, 32'h1234_52B7, 1'b0, 1'b0};
    vecs[4]  = '{1'b0, 32'h0,         7'h37, 5'd5,  5'd0, 5'd0, 3'd0, 7'h00, 32'h1234_5001, 1'b1, 32'h1234_52B7, 1'b1, 1'b0};
    vecs[5]  = '{1'b1, 32'h0000_0400, 7'h13, 5'd1,  5'd0, 5'd0, 3'd0, 7'h00, 32'h0000_0800, 1'b1, 32'h8000_0093, 1'b1, 1'b0};
    vecs[6]  = '{1'b1, 32'h0000_0500, 7'h63, 5'd0,  5'd1, 5'd2, 3'd0, 7'h00, 32'h0000_0006, 1'b0, 32'h0020_8363, 1'b0, 1'b0};
    vecs[7]  = '{1'b0, 32'h0,         7'h63, 5'd0,  5'd1, 5'd2, 3'd0, 7'h00, 32'h0000_0007, 1'b1, 32'h0020_8363, 1'b1, 1'b0};
    vecs[8]  = '{1'b1, 32'h0000_0600, 7'h33, 5'd3,  5'd1, 5'd2, 3'd0, 7'h00, 32'hDEAD_BEEF, 1'b0, 32'h0020_81B3, 1'b0, 1'b0};
    vecs[9]  = '{1'b0, 32'h0,         7'h33, 5'd3,  5'd1, 5'd2, 3'd0, 7'h20, 32'h0000_0000, 1'b0, 32'h4020_81B3, 1'b0, 1'b0};
    vecs[10] = '{1'b0, 32'h0,         7'h23, 5'd0,  5'd1, 5'd2, 3'd2, 7'h00, 32'hFFFF_FFFC, 1'b0, 32'hFE20_AE23, 1'b0, 1'b0};
    vecs[11] = '{1'b0, 32'h0,         7'h03, 5'd5,  5'd2, 5'd0, 3'd2, 7'h00, 32'h0000_0008, 1'b0, 32'h0081_2283, 1'b0, 1'b0};
    vecs[12] = '{1'b0, 32'h0,         7'h67, 5'd0,  5'd1, 5'd0, 3'd0, 7'h00, 32'h0000_0000, 1'b0, 32'h0000_8067, 1'b0, 1'b0};
    vecs[13] = '{1'b0, 32'h0,         7'h6F, 5'd0,  5'd0, 5'd0, 3'd0, 7'h00, 32'h0000_0003, 1'b1, 32'h0020_006F, 1'b1, 1'b0};
    vecs[14] = '{1'b1, 32'h0000_0700, 7'h7F, 5'd1,  5'd2, 5'd3, 3'd1, 7'h00, 32'h0000_0000, 1'b1, 32'h0000_0013, 1'b0, 1'b1};
    vecs[15] = '{1'b1, 32'h0000_0800, 7'h13, 5'd1,  5'd0, 5'd0, 3'd0, 7'h00, 32'h0000_0005, 1'b1, 32'h0050_0093, 1'b0, 1'b0};
    vecs[16] = '{1'b1, 32'hFFFF_FFFC, 7'h13, 5'd2,  5'd0, 5'd0, 3'd0, 7'h00, 32'hFFFF_FFFF, 1'b0, 32'hFFF0_0113, 1'b0, 1'b0};
    vecs[17] = '{1'b0, 32'h0,         7'h13, 5'd1,  5'd0, 5'd0, 3'd0, 7'h00, 32'h0000_0005, 1'b1, 32'h0050_0093, 1'b0, 1'b0};
    vecs[18] = '{1'b1, 32'h0000_0040, 7'h17, 5'd10, 5'd0, 5'd0, 3'd0, 7'h00, 32'h0000_1000, 1'b1, 32'h0000_1517, 1'b0, 1'b0};

    rst = 1'b1;
    start = 1'b0;
    base_addr = 32'h0;
    bus.in_valid = 1'b0;
    bus.in_opcode = 7'h0;
    bus.in_rd = 5'h0;
    bus.in_rs1 = 5'h0;
    bus.in_rs2 = 5'h0;
    bus.in_funct3 = 3'h0;
    bus.in_funct7 = 7'h0;
    bus.in_imm = 32'h0;
    bus.in_last = 1'b0;
    bus.mem_ack = 1'b0;
    cnt_m = 0;
    addr_m = 32'h0;
    racc = 1'b0;
    oacc = 1'b0;
    seen = 0;
    repeat (3) @(negedge clk);

    chk("rst_we", 32'(bus.mem_we), 32'd0);
    chk("rst_ready", 32'(bus.in_ready), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_rerr", 32'(err_range), 32'd0);
    chk("rst_oerr", 32'(err_opcode), 32'd0);
    chk("rst_count", 32'(inst_count), 32'd0);
    chk("rst_addr", bus.mem_addr, 32'd0);
    chk("rst_wdata", bus.mem_wdata, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("idle_ready", 32'(bus.in_ready), 32'd0);

    for (int i = 0; i < int'(NVEC); i++) begin
      v = vecs[i];
      if (v.first) begin
        seen = done_cnt;
        do_start(v.base);
      end
      send(v, i % 4);
      if (v.last) begin
        chk("done_pulse", 32'(done), 32'd1);
        chk("done_busy", 32'(busy), 32'd1);
        @(negedge clk);
        chk("post_done", 32'(done), 32'd0);
        chk("post_busy", 32'(busy), 32'd0);
        chk("post_count", 32'(inst_count), 32'(cnt_m));
        chk("done_once", 32'(done_cnt - seen), 32'd1);
      end
    end

    // mem_ack while IDLE must not move the counter.
    bus.mem_ack = 1'b1;
    @(negedge clk);
    bus.mem_ack = 1'b0;
    @(negedge clk);
    chk("idle_ack_count", 32'(inst_count), 32'(cnt_m));
    chk("idle_ack_busy", 32'(busy), 32'd0);

    // start while busy is ignored: writes stay on the original base.
    do_start(32'h0000_0900);
    start = 1'b1;
    base_addr = 32'hDEAD_0000;
    @(negedge clk);
    start = 1'b0;
    v = vecs[0];
    v.last = 1'b0;
    send(v, 3);

    // Reset while a write is pending aborts the session.
    drive(vecs[9]);
    wait_we(ok);
    chk("pre_rst_we", 32'(bus.mem_we), 32'd1);
    chk("pre_rst_addr", bus.mem_addr, 32'h0000_0904);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_mid_we", 32'(bus.mem_we), 32'd0);
    chk("rst_mid_busy", 32'(busy), 32'd0);
    chk("rst_mid_count", 32'(inst_count), 32'd0);
    chk("rst_mid_ready", 32'(bus.in_ready), 32'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    chk("sb_empty", 32'(sb.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
